// File: rtl/sram_access_arbiter_if.sv
// Requester-side handshake bundle for sram_access_arbiter: write port, read port and busy status.
interface sram_access_arbiter_if #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
);
    logic              i_wr_req;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ack;
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              o_rd_ack;
    logic              o_rd_valid;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_busy;

    modport slave (
        input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
        output o_wr_ack, o_rd_ack, o_rd_valid, o_rd_data, o_busy
    );

    modport master (
        output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr,
        input  o_wr_ack, o_rd_ack, o_rd_valid, o_rd_data, o_busy
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// Serialises write (mic recorder) and read accesses onto one async 16-bit SRAM.
// Optional macro SRAM_ARB_RR_EN selects round-robin arbitration instead of fixed write priority.
module sram_access_arbiter #(
    parameter int unsigned ADDR_W        = 20,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    sram_access_arbiter_if.slave bus,
    output logic [ADDR_W-1:0]  o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0]  io_SRAM_DQ,
    output logic               o_SRAM_WE_N,
    output logic               o_SRAM_CE_N,
    output logic               o_SRAM_OE_N,
    output logic               o_SRAM_LB_N,
    output logic               o_SRAM_UB_N
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic              busy_q, busy_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              ce_n_q, ce_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              grant_wr, grant_rd;
`ifdef SRAM_ARB_RR_EN
    // 1 = write was granted last, 0 = read was granted last
    logic              last_grant_q, last_grant_d;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
`ifdef SRAM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef SRAM_ARB_RR_EN
                if (bus.i_wr_req && bus.i_rd_req) begin
                    grant_wr = !last_grant_q;
                    grant_rd = last_grant_q;
                end else begin
                    grant_wr = bus.i_wr_req;
                    grant_rd = bus.i_rd_req;
                end
`else
                grant_wr = bus.i_wr_req;
                grant_rd = bus.i_rd_req && !bus.i_wr_req;
`endif
                if (grant_wr) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                    addr_d  = bus.i_wr_addr;
                    wdata_d = bus.i_wr_data;
`ifdef SRAM_ARB_RR_EN
                    last_grant_d = 1'b1;
`endif
                end else if (grant_rd) begin
                    state_d = READ;
                    cnt_d   = '0;
                    addr_d  = bus.i_rd_addr;
`ifdef SRAM_ARB_RR_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            WRITE, READ: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (state_q == READ) begin
                        rd_data_d  = io_SRAM_DQ;
                        rd_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes follow the state being entered so they are valid for the whole access
        we_n_d   = (state_d != WRITE);
        oe_n_d   = (state_d != READ);
        ce_n_d   = (state_d == IDLE);
        dq_oe_d  = (state_d == WRITE);
        busy_d   = (state_d != IDLE);
        wr_ack_d = (state_d == WRITE) && (cnt_d == LAST_CNT);
        rd_ack_d = (state_d == READ)  && (cnt_d == LAST_CNT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            ce_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            busy_q     <= busy_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            ce_n_q     <= ce_n_d;
            dq_oe_q    <= dq_oe_d;
`ifdef SRAM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign io_SRAM_DQ     = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign o_SRAM_ADDR    = addr_q;
    assign o_SRAM_WE_N    = we_n_q;
    assign o_SRAM_OE_N    = oe_n_q;
    assign o_SRAM_CE_N    = ce_n_q;
    assign o_SRAM_LB_N    = ce_n_q;
    assign o_SRAM_UB_N    = ce_n_q;
    assign bus.o_wr_ack   = wr_ack_q;
    assign bus.o_rd_ack   = rd_ack_q;
    assign bus.o_rd_valid = rd_valid_q;
    assign bus.o_rd_data  = rd_data_q;
    assign bus.o_busy     = busy_q;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter with a behavioural async SRAM model.
module tb_sram_access_arbiter;
    localparam int unsigned AC = 2;

    typedef struct {
        bit          is_wr;
        logic [19:0] addr;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst3 = 1'b1;
    always #5 clk = ~clk;

    sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus ();
    sram_access_arbiter_if #(.ADDR_W(20), .DATA_W(16)) bus3 ();

    logic [19:0] sram_addr, addr3;
    wire  [15:0] sram_dq, dq3;
    logic we_n, ce_n, oe_n, lb_n, ub_n;
    logic we3_n, ce3_n, oe3_n, lb3_n, ub3_n;

    sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(AC)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus),
        .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
        .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
        .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
    );

    sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(3)) dut3 (
        .i_clk(clk), .i_rst(rst3), .bus(bus3),
        .o_SRAM_ADDR(addr3), .io_SRAM_DQ(dq3),
        .o_SRAM_WE_N(we3_n), .o_SRAM_CE_N(ce3_n), .o_SRAM_OE_N(oe3_n),
        .o_SRAM_LB_N(lb3_n), .o_SRAM_UB_N(ub3_n)
    );

    // Async SRAM model, 256 words (low address byte)
    logic [15:0] mem [256];
    always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr[7:0]] <= sram_dq;
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

    int checks = 0;
    int errors = 0;
    exp_t        exp_q[$];
    logic [15:0] rd_exp_q[$];
    int wlen = 0;
    int rlen = 0;
    int ack3_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares each ack/valid against the scoreboard queues
    initial begin
        exp_t e;
        logic [15:0] d;
        forever begin
            @(negedge clk);
            wlen = we_n ? 0 : wlen + 1;
            rlen = oe_n ? 0 : rlen + 1;
            if (!oe_n) check("dq_not_driven_in_read", 32'(dut.dq_oe_q), 32'd0);
            if (bus.o_rd_valid) begin
                if (rd_exp_q.size() == 0) check("unexpected_rd_valid", 32'd1, 32'd0);
                else begin
                    d = rd_exp_q.pop_front();
                    check("rd_data", 32'(bus.o_rd_data), 32'(d));
                end
            end
            if (bus.o_wr_ack) begin
                if (exp_q.size() == 0) check("unexpected_wr_ack", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("wr_order", 32'(e.is_wr), 32'd1);
                    check("wr_addr", 32'(sram_addr), 32'(e.addr));
                    check("wr_dq", 32'(sram_dq), 32'(e.data));
                    check("wr_strobe_len", 32'(wlen), 32'(AC));
                end
            end
            if (bus.o_rd_ack) begin
                if (exp_q.size() == 0) check("unexpected_rd_ack", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("rd_order", 32'(e.is_wr), 32'd0);
                    check("rd_addr", 32'(sram_addr), 32'(e.addr));
                    check("rd_strobe_len", 32'(rlen), 32'(AC));
                    rd_exp_q.push_back(e.data);
                end
            end
        end
    end

    always @(negedge clk) if (bus3.o_wr_ack) ack3_cnt <= ack3_cnt + 1;

    task automatic push_exp(input bit is_wr, input logic [19:0] a, input logic [15:0] d);
        exp_t e;
        e.is_wr = is_wr; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input bit is_wr);
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (is_wr ? bus.o_wr_ack : bus.o_rd_ack) begin got = 1; break; end
        end
        if (!got) check(is_wr ? "wr_ack_timeout" : "rd_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [19:0] a, input logic [15:0] d);
        push_exp(1'b1, a, d);
        @(posedge clk); #1;
        bus.i_wr_req = 1'b1; bus.i_wr_addr = a; bus.i_wr_data = d;
        wait_ack(1'b1);
        @(posedge clk); #1;
        bus.i_wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [19:0] a, input logic [15:0] d);
        push_exp(1'b0, a, d);
        @(posedge clk); #1;
        bus.i_rd_req = 1'b1; bus.i_rd_addr = a;
        wait_ack(1'b0);
        @(posedge clk); #1;
        bus.i_rd_req = 1'b0;
    endtask

    initial begin
        int acks;
        bus.i_wr_req = 0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
        bus.i_rd_req = 0; bus.i_rd_addr = '0;
        bus3.i_wr_req = 0; bus3.i_wr_addr = '0; bus3.i_wr_data = '0;
        bus3.i_rd_req = 0; bus3.i_rd_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; rst3 = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_we_n", 32'(we_n), 32'd1);
        check("rst_ce_n", 32'(ce_n), 32'd1);
        check("rst_oe_n", 32'(oe_n), 32'd1);
        check("rst_lb_ub_n", 32'({lb_n, ub_n}), 32'd3);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_rd_data", 32'(bus.o_rd_data), 32'd0);
        check("rst_acks", 32'({bus.o_wr_ack, bus.o_rd_ack, bus.o_rd_valid}), 32'd0);
        check("rst_dq_oe", 32'(dut.dq_oe_q), 32'd0);

        // Single write then read-back
        do_write(20'h00012, 16'hBEEF);
        check("mem_after_write", 32'(mem[8'h12]), 32'h0000BEEF);
        do_read(20'h00012, 16'hBEEF);
        repeat (2) @(posedge clk);

        // Contended request: write first, one idle cycle, then read
        push_exp(1'b1, 20'h00020, 16'h1234);
        push_exp(1'b0, 20'h00020, 16'h1234);
        @(posedge clk); #1;
        bus.i_wr_req = 1'b1; bus.i_wr_addr = 20'h00020; bus.i_wr_data = 16'h1234;
        bus.i_rd_req = 1'b1; bus.i_rd_addr = 20'h00020;
        wait_ack(1'b1);
        @(posedge clk); #1;
        bus.i_wr_req = 1'b0;
        @(negedge clk);
        check("turnaround_idle", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        check("read_after_idle", 32'({bus.o_busy, oe_n}), 32'd2);
        wait_ack(1'b0);
        @(posedge clk); #1;
        bus.i_rd_req = 1'b0;
        repeat (2) @(posedge clk);

        // Address boundary
        do_write(20'hFFFFF, 16'hA5A5);
        do_read(20'hFFFFF, 16'hA5A5);
        do_read(20'h00012, 16'hBEEF);
        repeat (2) @(posedge clk);

        // Continuous dual requests for four grants
`ifdef SRAM_ARB_RR_EN
        push_exp(1'b1, 20'h00030, 16'h5555);
        push_exp(1'b0, 20'h00030, 16'h5555);
        push_exp(1'b1, 20'h00030, 16'h5555);
        push_exp(1'b0, 20'h00030, 16'h5555);
`else
        for (int i = 0; i < 4; i++) push_exp(1'b1, 20'h00030, 16'h5555);
`endif
        @(posedge clk); #1;
        bus.i_wr_req = 1'b1; bus.i_wr_addr = 20'h00030; bus.i_wr_data = 16'h5555;
        bus.i_rd_req = 1'b1; bus.i_rd_addr = 20'h00030;
        acks = 0;
        for (int i = 0; i < 60 && acks < 4; i++) begin
            @(negedge clk);
            if (bus.o_wr_ack || bus.o_rd_ack) acks++;
        end
        check("continuous_grants", 32'(acks), 32'd4);
        @(posedge clk); #1;
        bus.i_wr_req = 1'b0; bus.i_rd_req = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);

        // Reset in the 2nd WRITE cycle of a 3-cycle access aborts it
        @(posedge clk); #1;
        bus3.i_wr_req = 1'b1; bus3.i_wr_addr = 20'h00044; bus3.i_wr_data = 16'hCAFE;
        begin
            bit got = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (!we3_n) begin got = 1; break; end
            end
            check("abort_write_started", 32'(got), 32'd1);
        end
        @(posedge clk); #1;
        rst3 = 1'b1; bus3.i_wr_req = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b0;
        @(negedge clk);
        check("abort_we_n", 32'(we3_n), 32'd1);
        check("abort_ce_n", 32'(ce3_n), 32'd1);
        check("abort_busy", 32'(bus3.o_busy), 32'd0);
        check("abort_dq_oe", 32'(dut3.dq_oe_q), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_no_ack", 32'(ack3_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
Shares the single external 16-bit asynchronous SRAM between two requesters.
- Write port: mic sample recorder, fed from i_mic_data.
- Read port: VGA/display or processing reader.
The block sequences every SRAM access: address and data latching, strobe generation, DQ tri-state control and read-data capture. It sits inside Top, between the datapath and the o_SRAM_*/io_SRAM_DQ pins.

Parameters:
ADDR_W, 20, SRAM address width
DATA_W, 16, SRAM data width
ACCESS_CYCLES, 2, clock cycles per SRAM strobe phase (legal range 1..15)

Ports:
i_clk  input  1  system clock (50 MHz domain)
i_rst  input  1  synchronous active-high reset
i_wr_req  input  1  write request; held until o_wr_ack
i_wr_addr  input  ADDR_W  write address; stable while i_wr_req=1
i_wr_data  input  DATA_W  write data; stable while i_wr_req=1
o_wr_ack  output  1  1-cycle pulse; write completed
i_rd_req  input  1  read request; held until o_rd_ack
i_rd_addr  input  ADDR_W  read address; stable while i_rd_req=1
o_rd_ack  output  1  1-cycle pulse; read strobe finished
o_rd_valid  output  1  1-cycle pulse; o_rd_data valid
o_rd_data  output  DATA_W  captured read data; holds until next capture
o_busy  output  1  high in any non-IDLE state
o_SRAM_ADDR  output  ADDR_W  SRAM address
io_SRAM_DQ  inout  DATA_W  SRAM data bus
o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  output  1 each  SRAM strobes, active low

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high. All state and outputs are registered.
- Reset values:
  - state=IDLE
  - o_SRAM_ADDR=0
  - WE_N/CE_N/OE_N/LB_N/UB_N=1
  - io_SRAM_DQ='z
  - o_wr_ack, o_rd_ack, o_rd_valid, o_busy=0
  - o_rd_data=0
  - cycle counter=0
- States:
  - IDLE: CE_N=OE_N=WE_N=LB_N=UB_N=1, DQ='z.
    - Samples requests. On a grant, latches address (and write data), loads counter=0 and moves to WRITE or READ.
    - No request: stay in IDLE.
  - WRITE: CE_N=LB_N=UB_N=0, WE_N=0, OE_N=1.
    - DQ driven with latched data for exactly ACCESS_CYCLES cycles.
    - o_wr_ack=1 in the last WRITE cycle.
    - Then IDLE.
  - READ: CE_N=LB_N=UB_N=0, OE_N=0, WE_N=1, DQ='z for ACCESS_CYCLES cycles.
    - o_rd_ack=1 in the last READ cycle.
    - io_SRAM_DQ is registered into o_rd_data at the end of that cycle.
    - o_rd_valid=1 in the following cycle (IDLE).
- DQ output enable is asserted only in WRITE. The mandatory IDLE cycle between accesses provides bus turnaround. Max throughput is one access per ACCESS_CYCLES+1 cycles.
- o_SRAM_ADDR stays constant for the whole access and retains its last value in IDLE.
- Arbitration (default, fixed priority): write beats read when both are requested in the same IDLE cycle. Mic samples must never be dropped.
- Requesters:
  - May drop a request only after its ack.
  - May re-assert in the cycle after the ack. That request is sampled in the next IDLE.
  - A request that drops without an ack is legal only in IDLE and is simply not granted.
- Read-after-write: a read of an address written earlier returns the new data. Accesses are strictly serialised.
- Reset mid-operation: the next edge returns to IDLE. Strobes go to 1, DQ goes to 'z, and no ack or valid is issued for the aborted access.
- Simultaneous o_rd_valid (previous read) and a new grant in the same IDLE cycle is legal.

Optional Feature:
SRAM_ARB_RR_EN
- Defined: round-robin arbitration. A 1-bit last_grant register (reset=read, so the first contended grant goes to write). When both requests are present in IDLE, grant the port not granted last; an uncontended request is granted immediately. Under continuous dual requests the sequence is W,R,W,R...
- Undefined: fixed write priority as above; no last_grant register is synthesised.

Test Plan:
- Reset: hold i_rst 1 cycle -> WE_N=CE_N=OE_N=LB_N=UB_N=1, DQ=z, o_busy=0, o_rd_data=0, no acks.
- Single write, addr 0x00012 data 0xBEEF -> 2 cycles of WE_N=0 with ADDR=0x00012 and DQ=0xBEEF; o_wr_ack in 2nd cycle; SRAM model holds 0xBEEF.
- Read 0x00012 after that write -> OE_N=0 for 2 cycles, o_rd_ack in 2nd, o_rd_valid next cycle with o_rd_data=0xBEEF; DQ never driven by DUT.
- Write 0x00020=0x1234 and read 0x00020 requested in the same cycle -> write first, then read; o_rd_data=0x1234; exactly one IDLE cycle between the two.
- Continuous i_wr_req and i_rd_req for 12 cycles -> default: writes only, one per 3 cycles; with SRAM_ARB_RR_EN: W,R,W alternation.
- i_rst asserted in 2nd WRITE cycle (ACCESS_CYCLES=3) -> next cycle WE_N=1, DQ=z, state IDLE, o_wr_ack never pulses.
